sim_mem_bridge: RTL and testbench
=================================

// Module: sim_mem_bridge
// PURPOSE
//  Parametrised simulation memory front-end for the difftest top level.
//  Merges N_CH core request channels (ch0 = icache, ch1 = dcache, ...) onto one
//  RAMHelper-style port using round-robin arbitration.
//  Supports configurable response latency, per-channel response FIFOs and real
//  rsp backpressure. Replaces the fixed always-ready, 1-cycle, two-RAM hookup.
// PARAMETERS
//  N_CH       2             number of request channels (1..8)
//  ADDR_W     64            request address width
//  DATA_W     64            data width; power of 2, >= 32
//  IDX_W      28            RAMHelper index width
//  BASE_ADDR  64'h8000_0000 address mapped to index 0
//  LAT        1             cycles from grant to FIFO push (1..8)
//  FIFO_DEPTH 4             rsp entries per channel (power of 2, >= 2)
// PORTS
//  clock      in   1               single clock, rising edge
//  reset_n    in   1               synchronous, active-low reset
//  cmd_valid  in   N_CH            request valid, one bit per channel
//  cmd_ready  out  N_CH            request accepted this cycle
//  cmd_addr   in   N_CH*ADDR_W     byte address; channel c at [c*ADDR_W +: ADDR_W]
//  cmd_wen    in   N_CH            1 = write, 0 = read
//  cmd_wdata  in   N_CH*DATA_W     write data
//  cmd_wstrb  in   N_CH*DATA_W/8   byte write strobes
//  rsp_valid  out  N_CH            read data available
//  rsp_ready  in   N_CH            consumer accepts read data
//  rsp_data   out  N_CH*DATA_W     read data, full word
//  mem_en     out  1               RAMHelper enable
//  mem_ridx   out  IDX_W           read index
//  mem_rdata  in   DATA_W          read data, valid in the same cycle as mem_en/mem_ridx
//  mem_widx   out  IDX_W           write index (= mem_ridx)
//  mem_wdata  out  DATA_W          write data
//  mem_wmask  out  DATA_W          bit mask; each wstrb bit expands to 8 bits
//  mem_wen    out  1               write enable (qualified by mem_en)
// BEHAVIOUR
//  Reset (reset_n = 0 at a clock edge):
//   - Outputs: rsp_valid, cmd_ready, mem_en and mem_wen = 0.
//   - Internal state cleared: FIFOs flushed, delay pipe cleared, credits =
//     FIFO_DEPTH, RR pointer = 0.
//   - Reset mid-operation drops all in-flight reads; no response is produced later.
//  Index: idx = ((addr - BASE_ADDR) >> log2(DATA_W/8))[IDX_W-1:0].
//   - Sub-word address bits are ignored. Out-of-range addresses wrap silently.
//  Eligibility: channel c is eligible when
//   - cmd_valid[c] = 1, and
//   - (cmd_wen[c] = 1 or credit[c] > 0).
//   credit[c] = FIFO_DEPTH - fifo_count[c] - inflight_reads[c].
//  Arbitration:
//   - At most one grant per cycle, round-robin from the RR pointer.
//   - On a grant, the pointer moves to (granted + 1) mod N_CH; otherwise it holds.
//  Handshake:
//   - cmd_ready[c] = grant[c]. This is combinational from cmd_valid (a permitted path).
//   - A request transfers when cmd_valid & cmd_ready.
//   - Ungranted requests must hold their payload stable.
//  Memory port: mem_en, index, wdata, mask and wen are driven combinationally from
//   the granted channel. Writes commit at that clock edge.
//  Writes: no response is generated; credits are unaffected.
//  Reads: {ch, mem_rdata} enters a LAT-stage delay pipe.
//   - The tag reaches the channel FIFO exactly LAT cycles after the grant.
//   - With an empty FIFO and rsp_ready = 1, the first rsp_valid is seen LAT cycles
//     after cmd_ready.
//  FIFO:
//   - rsp_valid = FIFO not empty; rsp_data = head entry.
//   - Pop on rsp_valid & rsp_ready.
//   - Push and pop in the same cycle are legal at any occupancy.
//   - Overflow is impossible by construction of the credit count. A simulation
//     assertion fires if a push ever hits a full FIFO.
//  Ordering: responses are in request order per channel. There is no ordering
//   across channels.
//  Counters:
//   - inflight_reads increments on a read grant and decrements on its FIFO push.
//   - Both in the same cycle: the count holds.
//  Throughput: one request per cycle aggregate. A single channel with rsp_ready = 1
//   and FIFO_DEPTH >= LAT+1 sustains one read per cycle.
// STRUCTURE
//  Shared header sim_mem_defs.vh:
//   - BASE_ADDR default
//   - channel-ID width macro CH_W = clog2(N_CH), min 1
//   - wstrb-to-wmask expansion macro
//  Sub-module sim_mem_rsp_fifo (DATA_W, FIFO_DEPTH):
//   - count-based sync FIFO with push, pop, full, empty and count
//   - one instance per channel
//  Top level holds: RR arbiter, credit logic, delay pipe (generate over LAT).
// TESTING
//  1. Reset release, N_CH=2, LAT=1: outputs stay 0. Read ch0 @0x8000_0008 (mem word
//     1 = 0xDEAD) -> mem_ridx = 1; rsp_valid[0] = 1 one cycle later with data 0xDEAD.
//  2. Write ch1 @0x8000_0010, wdata 0x1122334455667788, wstrb 0x0F ->
//     mem_wmask = 0x00000000FFFFFFFF; no rsp_valid. Readback returns the low word only.
//  3. Both channels hold reads for 6 cycles -> grants alternate ch0, ch1, ...;
//     each channel gets 3 responses, in order.
//  4. LAT=3, FIFO_DEPTH=4, rsp_ready[0] = 0, ch0 streams reads -> exactly 4 grants,
//     then cmd_ready[0] = 0. Raise rsp_ready -> 4 responses in order, then issue resumes.
//  5. Assert reset_n = 0 with 2 reads in flight (LAT=3) -> no rsp_valid afterwards;
//     credit returns to FIFO_DEPTH; RR pointer = 0.
//  6. ch0 read and ch1 write valid in the same cycle, pointer = 1 -> ch1 write
//     granted first, ch0 read granted next cycle.

Source files
------------

// File: rtl/sim_mem_bridge_pkg.sv
// Shared definitions for the simulation memory bridge: default base address
// and width helpers used by the top level and the response FIFO.
package sim_mem_bridge_pkg;

    localparam logic [63:0] SIM_MEM_BASE = 64'h8000_0000;

    // Channel-ID width; a single channel still carries a one-bit tag.
    function automatic int ch_width(input int n_ch);
        return (n_ch <= 1) ? 1 : $clog2(n_ch);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sim_mem_bridge_rsp_fifo.sv
// Count-based synchronous response FIFO; one instance per request channel.
// Push and pop may coincide at any occupancy, including full.
module sim_mem_bridge_rsp_fifo
    import sim_mem_bridge_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           push,
    input  logic [DATA_W-1:0]              push_data,
    input  logic                           pop,
    output logic                           full,
    output logic                           empty,
    output logic [cnt_width(FIFO_DEPTH)-1:0] count,
    output logic [DATA_W-1:0]              head
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = cnt_width(FIFO_DEPTH);

    logic [DATA_W-1:0] store [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;

    assign count = cnt;
    assign full  = (cnt == CNT_W'(FIFO_DEPTH));
    assign empty = (cnt == '0);
    assign head  = store[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) store[wr_ptr] <= push_data;
    end

    // The credit scheme upstream must make this unreachable.
    assert property (@(posedge clock) disable iff (!reset_n) !(push && full && !pop));

endmodule

// File: rtl/sim_mem_bridge.sv
// Round-robin merge of N_CH request channels onto one RAMHelper-style port, with a
// LAT-deep read-return pipe feeding credit-protected per-channel response FIFOs.
module sim_mem_bridge
    import sim_mem_bridge_pkg::*;
#(
    parameter int                N_CH       = 2,
    parameter int                ADDR_W     = 64,
    parameter int                DATA_W     = 64,
    parameter int                IDX_W      = 28,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(SIM_MEM_BASE),
    parameter int                LAT        = 1,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [N_CH-1:0]          cmd_valid,
    output logic [N_CH-1:0]          cmd_ready,
    input  logic [N_CH*ADDR_W-1:0]   cmd_addr,
    input  logic [N_CH-1:0]          cmd_wen,
    input  logic [N_CH*DATA_W-1:0]   cmd_wdata,
    input  logic [N_CH*DATA_W/8-1:0] cmd_wstrb,
    output logic [N_CH-1:0]          rsp_valid,
    input  logic [N_CH-1:0]          rsp_ready,
    output logic [N_CH*DATA_W-1:0]   rsp_data,
    output logic                     mem_en,
    output logic [IDX_W-1:0]         mem_ridx,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [IDX_W-1:0]         mem_widx,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [DATA_W-1:0]        mem_wmask,
    output logic                     mem_wen
);
    localparam int CH_W  = ch_width(N_CH);
    localparam int CNT_W = cnt_width(FIFO_DEPTH);
    localparam int OFS_W = $clog2(DATA_W / 8);

    logic [CH_W-1:0]     rr_ptr;
    logic [N_CH-1:0]     elig;
    logic                gnt_any;
    logic [CH_W-1:0]     gnt_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W/8-1:0] sel_wstrb;
    logic                sel_wen;

    // First eligible channel at or after the pointer wins.
    always_comb begin
        int c;
        c       = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            c = (int'(rr_ptr) + i) % N_CH;
            if (!gnt_any && elig[c]) begin
                gnt_any = 1'b1;
                gnt_idx = CH_W'(c);
            end
        end
    end

    always_comb begin
        cmd_ready = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        sel_wen   = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (gnt_any && gnt_idx == CH_W'(c)) begin
                cmd_ready[c] = 1'b1;
                sel_addr     = cmd_addr[c*ADDR_W +: ADDR_W];
                sel_wdata    = cmd_wdata[c*DATA_W +: DATA_W];
                sel_wstrb    = cmd_wstrb[c*(DATA_W/8) +: DATA_W/8];
                sel_wen      = cmd_wen[c];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n)     rr_ptr <= '0;
        else if (gnt_any) rr_ptr <= (int'(gnt_idx) == N_CH - 1) ? '0 : gnt_idx + 1'b1;
    end

    assign mem_en    = gnt_any;
    assign mem_wen   = gnt_any && sel_wen;
    assign mem_ridx  = IDX_W'((sel_addr - BASE_ADDR) >> OFS_W);
    assign mem_widx  = mem_ridx;
    assign mem_wdata = sel_wdata;

    for (genvar b = 0; b < DATA_W / 8; b++) begin : g_mask
        assign mem_wmask[b*8 +: 8] = {8{sel_wstrb[b]}};
    end

    // Stage p0: grant cycle; RAMHelper read data is already valid here.
    logic              rd_vld_p0;
    logic [CH_W-1:0]   rd_ch_p0;
    logic [DATA_W-1:0] rd_data_p0;
    logic              push_vld;
    logic [CH_W-1:0]   push_ch;
    logic [DATA_W-1:0] push_data;

    assign rd_vld_p0  = gnt_any && !sel_wen;
    assign rd_ch_p0   = gnt_idx;
    assign rd_data_p0 = mem_rdata;

    if (LAT == 1) begin : g_lat1
        assign push_vld  = rd_vld_p0;
        assign push_ch   = rd_ch_p0;
        assign push_data = rd_data_p0;
    end else begin : g_latn
        // Stages p1..p(LAT-1): registered delay; the last one pushes into the FIFO.
        logic              vld_pn  [1:LAT-1];
        logic [CH_W-1:0]   ch_pn   [1:LAT-1];
        logic [DATA_W-1:0] data_pn [1:LAT-1];

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                for (int k = 1; k < LAT; k++) vld_pn[k] <= 1'b0;
            end else begin
                vld_pn[1] <= rd_vld_p0;
                for (int k = 2; k < LAT; k++) vld_pn[k] <= vld_pn[k-1];
            end
        end

        always_ff @(posedge clock) begin
            ch_pn[1]   <= rd_ch_p0;
            data_pn[1] <= rd_data_p0;
            for (int k = 2; k < LAT; k++) begin
                ch_pn[k]   <= ch_pn[k-1];
                data_pn[k] <= data_pn[k-1];
            end
        end

        assign push_vld  = vld_pn[LAT-1];
        assign push_ch   = ch_pn[LAT-1];
        assign push_data = data_pn[LAT-1];
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic             push_c;
        logic             pop_c;
        logic             rd_gnt_c;
        logic             fifo_full;
        logic             fifo_empty;
        logic [CNT_W-1:0] fifo_count;
        logic [CNT_W-1:0] inflight;

        assign push_c   = push_vld && (push_ch == CH_W'(c));
        assign pop_c    = rsp_valid[c] && rsp_ready[c];
        assign rd_gnt_c = cmd_ready[c] && !cmd_wen[c];

        // A read needs a FIFO slot that no earlier read has already claimed.
        assign elig[c] = reset_n && cmd_valid[c] &&
                         (cmd_wen[c] || (!fifo_full &&
                          ({1'b0, fifo_count} + {1'b0, inflight} < (CNT_W+1)'(FIFO_DEPTH))));

        always_ff @(posedge clock) begin
            if (!reset_n)                  inflight <= '0;
            else if (rd_gnt_c && !push_c)  inflight <= inflight + 1'b1;
            else if (push_c && !rd_gnt_c)  inflight <= inflight - 1'b1;
        end

        sim_mem_bridge_rsp_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clock     (clock),
            .reset_n   (reset_n),
            .push      (push_c),
            .push_data (push_data),
            .pop       (pop_c),
            .full      (fifo_full),
            .empty     (fifo_empty),
            .count     (fifo_count),
            .head      (rsp_data[c*DATA_W +: DATA_W])
        );

        assign rsp_valid[c] = !fifo_empty;
    end

endmodule

// File: tb/tb_sim_mem_bridge.sv
// Directed bench for sim_mem_bridge: one LAT=1 instance (a_*) and one LAT=3 instance (b_*),
// each backed by a small RAMHelper model with combinational reads.
module tb_sim_mem_bridge;

    logic clk;
    logic reset_a, reset_b, mem_load;
    int   n_tests, n_fail;

    logic [1:0]   a_cmd_valid, a_cmd_ready, a_cmd_wen, a_rsp_valid, a_rsp_ready;
    logic [127:0] a_cmd_addr, a_cmd_wdata, a_rsp_data;
    logic [15:0]  a_cmd_wstrb;
    logic         a_mem_en, a_mem_wen;
    logic [27:0]  a_mem_ridx, a_mem_widx;
    logic [63:0]  a_mem_rdata, a_mem_wdata, a_mem_wmask;

    logic [1:0]   b_cmd_valid, b_cmd_ready, b_cmd_wen, b_rsp_valid, b_rsp_ready;
    logic [127:0] b_cmd_addr, b_cmd_wdata, b_rsp_data;
    logic [15:0]  b_cmd_wstrb;
    logic         b_mem_en, b_mem_wen;
    logic [27:0]  b_mem_ridx, b_mem_widx;
    logic [63:0]  b_mem_rdata, b_mem_wdata, b_mem_wmask;

    logic [63:0] mem_a [64];
    logic [63:0] mem_b [64];

    sim_mem_bridge #(.N_CH(2), .LAT(1), .FIFO_DEPTH(4)) u_dut_a (
        .clock(clk), .reset_n(reset_a),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_addr(a_cmd_addr),
        .cmd_wen(a_cmd_wen), .cmd_wdata(a_cmd_wdata), .cmd_wstrb(a_cmd_wstrb),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
        .mem_en(a_mem_en), .mem_ridx(a_mem_ridx), .mem_rdata(a_mem_rdata),
        .mem_widx(a_mem_widx), .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask),
        .mem_wen(a_mem_wen)
    );

    sim_mem_bridge #(.N_CH(2), .LAT(3), .FIFO_DEPTH(4)) u_dut_b (
        .clock(clk), .reset_n(reset_b),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_addr(b_cmd_addr),
        .cmd_wen(b_cmd_wen), .cmd_wdata(b_cmd_wdata), .cmd_wstrb(b_cmd_wstrb),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
        .mem_en(b_mem_en), .mem_ridx(b_mem_ridx), .mem_rdata(b_mem_rdata),
        .mem_widx(b_mem_widx), .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask),
        .mem_wen(b_mem_wen)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] pat(input int i);
        if (i == 1) return 64'hDEAD;
        if (i >= 8 && i <= 10) return 64'h100 + 64'(i - 8);
        if (i >= 12 && i <= 14) return 64'h200 + 64'(i - 12);
        if (i >= 16 && i <= 23) return 64'h300 + 64'(i - 16);
        return 64'h0;
    endfunction

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) begin
                mem_a[i] <= pat(i);
                mem_b[i] <= pat(i);
            end
        end else begin
            if (a_mem_en && a_mem_wen)
                mem_a[a_mem_widx[5:0]] <= (mem_a[a_mem_widx[5:0]] & ~a_mem_wmask) | (a_mem_wdata & a_mem_wmask);
            if (b_mem_en && b_mem_wen)
                mem_b[b_mem_widx[5:0]] <= (mem_b[b_mem_widx[5:0]] & ~b_mem_wmask) | (b_mem_wdata & b_mem_wmask);
        end
    end

    assign a_mem_rdata = mem_a[a_mem_ridx[5:0]];
    assign b_mem_rdata = mem_b[b_mem_ridx[5:0]];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_a = 1'b0; reset_b = 1'b0; mem_load = 1'b1;
        a_cmd_valid = 2'b11; b_cmd_valid = 2'b11;
        a_cmd_addr = {2{64'h8000_0000}}; b_cmd_addr = {2{64'h8000_0000}};
        a_rsp_ready = 2'b11; b_rsp_ready = 2'b11;
        repeat (3) tick();
        mem_load = 1'b0;
        #4;
        n_tests++; if (a_cmd_ready !== 2'b00) begin n_fail++; $display("FAIL rst_a_ready: got %b want 00", a_cmd_ready); end
        n_tests++; if (a_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_a_rsp_valid: got %b want 00", a_rsp_valid); end
        n_tests++; if ({a_mem_en, a_mem_wen} !== 2'b00) begin n_fail++; $display("FAIL rst_a_mem: got %b want 00", {a_mem_en, a_mem_wen}); end
        n_tests++; if ({b_cmd_ready, b_rsp_valid, b_mem_en, b_mem_wen} !== 6'b0) begin n_fail++; $display("FAIL rst_b_outs: got %b want 000000", {b_cmd_ready, b_rsp_valid, b_mem_en, b_mem_wen}); end
        tick();
        a_cmd_valid = 2'b00; b_cmd_valid = 2'b00;
        reset_a = 1'b1; reset_b = 1'b1;
        tick();
        #4;
        n_tests++; if ({a_rsp_valid, a_mem_en, b_rsp_valid, b_mem_en} !== 6'b0) begin n_fail++; $display("FAIL rel_outs: got %b want 000000", {a_rsp_valid, a_mem_en, b_rsp_valid, b_mem_en}); end
        tick();
    endtask

    task automatic test_read;
        a_cmd_addr[63:0] = 64'h8000_0008; a_cmd_wen = 2'b00; a_cmd_valid = 2'b01;
        #4;
        n_tests++; if (a_cmd_ready !== 2'b01) begin n_fail++; $display("FAIL rd_ready: got %b want 01", a_cmd_ready); end
        n_tests++; if (a_mem_en !== 1'b1 || a_mem_ridx !== 28'd1) begin n_fail++; $display("FAIL rd_idx: got en=%b idx=%0d want en=1 idx=1", a_mem_en, a_mem_ridx); end
        n_tests++; if (a_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rd_early_rsp: got %b want 00", a_rsp_valid); end
        tick();
        a_cmd_valid = 2'b00;
        #4;
        n_tests++; if (a_rsp_valid !== 2'b01) begin n_fail++; $display("FAIL rd_rsp_valid: got %b want 01", a_rsp_valid); end
        n_tests++; if (a_rsp_data[63:0] !== 64'hDEAD) begin n_fail++; $display("FAIL rd_rsp_data: got %h want dead", a_rsp_data[63:0]); end
        tick();
        #4;
        n_tests++; if (a_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rd_pop: got %b want 00", a_rsp_valid); end
        tick();
    endtask

    task automatic test_write;
        a_cmd_addr[127:64] = 64'h8000_0010; a_cmd_wdata[127:64] = 64'h1122_3344_5566_7788;
        a_cmd_wstrb[15:8] = 8'h0F; a_cmd_wen = 2'b10; a_cmd_valid = 2'b10;
        #4;
        n_tests++; if (a_cmd_ready !== 2'b10) begin n_fail++; $display("FAIL wr_ready: got %b want 10", a_cmd_ready); end
        n_tests++; if (a_mem_wen !== 1'b1 || a_mem_widx !== 28'd2) begin n_fail++; $display("FAIL wr_port: got wen=%b idx=%0d want wen=1 idx=2", a_mem_wen, a_mem_widx); end
        n_tests++; if (a_mem_wmask !== 64'h0000_0000_FFFF_FFFF) begin n_fail++; $display("FAIL wr_mask: got %h want 00000000ffffffff", a_mem_wmask); end
        n_tests++; if (a_mem_wdata !== 64'h1122_3344_5566_7788) begin n_fail++; $display("FAIL wr_data: got %h want 1122334455667788", a_mem_wdata); end
        tick();
        a_cmd_valid = 2'b00;
        #4;
        n_tests++; if (a_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL wr_no_rsp: got %b want 00", a_rsp_valid); end
        tick();
        a_cmd_wen = 2'b00; a_cmd_valid = 2'b10;
        #4;
        n_tests++; if (a_cmd_ready !== 2'b10 || a_mem_wen !== 1'b0) begin n_fail++; $display("FAIL rb_issue: got ready=%b wen=%b want ready=10 wen=0", a_cmd_ready, a_mem_wen); end
        tick();
        a_cmd_valid = 2'b00;
        #4;
        n_tests++; if (a_rsp_valid !== 2'b10) begin n_fail++; $display("FAIL rb_valid: got %b want 10", a_rsp_valid); end
        n_tests++; if (a_rsp_data[127:64] !== 64'h0000_0000_5566_7788) begin n_fail++; $display("FAIL rb_data: got %h want 0000000055667788", a_rsp_data[127:64]); end
        tick();
    endtask

    task automatic test_round_robin;
        int ia, ib, ch, j;
        logic [63:0] got, exp;
        ia = 0; ib = 0;
        a_cmd_wen = 2'b00; a_rsp_ready = 2'b11;
        for (int k = 0; k < 7; k++) begin
            a_cmd_valid = (k < 6) ? 2'b11 : 2'b00;
            a_cmd_addr[63:0]   = 64'h8000_0040 + 64'(8 * ia);
            a_cmd_addr[127:64] = 64'h8000_0060 + 64'(8 * ib);
            #4;
            if (k < 6) begin
                n_tests++;
                if (a_cmd_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", k, a_cmd_ready, (k % 2 == 0) ? 2'b01 : 2'b10); end
            end
            if (k >= 1) begin
                ch  = (k - 1) % 2;
                j   = (k - 1) / 2;
                exp = (ch == 1) ? 64'h200 + 64'(j) : 64'h100 + 64'(j);
                got = (ch == 1) ? a_rsp_data[127:64] : a_rsp_data[63:0];
                n_tests++;
                if (a_rsp_valid !== ((ch == 1) ? 2'b10 : 2'b01) || got !== exp) begin n_fail++; $display("FAIL rr_rsp%0d: got valid=%b data=%h want ch%0d data=%h", k, a_rsp_valid, got, ch, exp); end
            end
            if (a_cmd_ready[0]) ia++;
            if (a_cmd_ready[1]) ib++;
            tick();
        end
        n_tests++; if (ia != 3 || ib != 3) begin n_fail++; $display("FAIL rr_counts: got ch0=%0d ch1=%0d want 3 and 3", ia, ib); end
    endtask

    task automatic test_credit_stall;
        int issued;
        issued = 0;
        b_cmd_wen = 2'b00; b_rsp_ready = 2'b00;
        for (int n = 0; n < 10; n++) begin
            b_cmd_valid = 2'b01;
            b_cmd_addr[63:0] = 64'h8000_0080 + 64'(8 * issued);
            #4;
            n_tests++; if (b_cmd_ready !== ((n < 4) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL cr_ready%0d: got %b want %b", n, b_cmd_ready, (n < 4) ? 2'b01 : 2'b00); end
            n_tests++; if (b_rsp_valid !== ((n >= 3) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL cr_valid%0d: got %b want %b", n, b_rsp_valid, (n >= 3) ? 2'b01 : 2'b00); end
            if (n >= 3) begin
                n_tests++; if (b_rsp_data[63:0] !== 64'h300) begin n_fail++; $display("FAIL cr_head%0d: got %h want 300", n, b_rsp_data[63:0]); end
            end
            if (b_cmd_ready[0]) issued++;
            tick();
        end
        b_rsp_ready = 2'b01;
        for (int n = 0; n < 8; n++) begin
            b_cmd_valid = (n < 4) ? 2'b01 : 2'b00;
            b_cmd_addr[63:0] = 64'h8000_0080 + 64'(8 * issued);
            #4;
            if (n < 4) begin
                n_tests++; if (b_cmd_ready !== ((n == 0) ? 2'b00 : 2'b01)) begin n_fail++; $display("FAIL cr_resume%0d: got %b want %b", n, b_cmd_ready, (n == 0) ? 2'b00 : 2'b01); end
            end
            n_tests++;
            if (b_rsp_valid !== ((n < 7) ? 2'b01 : 2'b00) || (n < 7 && b_rsp_data[63:0] !== 64'h300 + 64'(n))) begin
                n_fail++; $display("FAIL cr_drain%0d: got valid=%b data=%h want valid=%b data=%h", n, b_rsp_valid, b_rsp_data[63:0], (n < 7) ? 2'b01 : 2'b00, 64'h300 + 64'(n));
            end
            if (b_cmd_ready[0]) issued++;
            tick();
        end
    endtask

    task automatic test_reset_inflight;
        b_cmd_wen = 2'b00; b_rsp_ready = 2'b01;
        for (int n = 0; n < 2; n++) begin
            b_cmd_valid = 2'b01;
            b_cmd_addr[63:0] = 64'h8000_0080 + 64'(8 * n);
            #4;
            n_tests++; if (b_cmd_ready !== 2'b01) begin n_fail++; $display("FAIL ri_issue%0d: got %b want 01", n, b_cmd_ready); end
            tick();
        end
        b_cmd_valid = 2'b00; reset_b = 1'b0;
        tick();
        reset_b = 1'b1;
        for (int n = 0; n < 6; n++) begin
            #4;
            n_tests++; if (b_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL ri_dropped%0d: got %b want 00", n, b_rsp_valid); end
            tick();
        end
        b_rsp_ready = 2'b00;
        b_cmd_addr = {64'h8000_0000, 64'h8000_0080};
        for (int n = 0; n < 6; n++) begin
            b_cmd_valid = (n == 0) ? 2'b11 : 2'b01;
            #4;
            n_tests++; if (b_cmd_ready !== ((n < 4) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL ri_credit%0d: got %b want %b", n, b_cmd_ready, (n < 4) ? 2'b01 : 2'b00); end
            tick();
        end
        b_cmd_valid = 2'b00; b_rsp_ready = 2'b11;
        repeat (8) tick();
    endtask

    task automatic test_write_priority;
        a_cmd_wen = 2'b00; a_rsp_ready = 2'b11;
        a_cmd_addr[63:0] = 64'h8000_0008; a_cmd_valid = 2'b01;
        #4;
        n_tests++; if (a_cmd_ready !== 2'b01) begin n_fail++; $display("FAIL pr_setup: got %b want 01", a_cmd_ready); end
        tick();
        a_cmd_valid = 2'b00;
        tick();
        a_cmd_addr = {64'h8000_00C0, 64'h8000_0040};
        a_cmd_wdata[127:64] = 64'hCAFE_F00D_1234_5678; a_cmd_wstrb[15:8] = 8'hFF;
        a_cmd_wen = 2'b10; a_cmd_valid = 2'b11;
        #4;
        n_tests++; if (a_cmd_ready !== 2'b10 || a_mem_wen !== 1'b1 || a_mem_widx !== 28'd24) begin n_fail++; $display("FAIL pr_first: got ready=%b wen=%b idx=%0d want ready=10 wen=1 idx=24", a_cmd_ready, a_mem_wen, a_mem_widx); end
        tick();
        a_cmd_valid = 2'b01;
        #4;
        n_tests++; if (a_cmd_ready !== 2'b01 || a_mem_wen !== 1'b0 || a_mem_ridx !== 28'd8) begin n_fail++; $display("FAIL pr_second: got ready=%b wen=%b idx=%0d want ready=01 wen=0 idx=8", a_cmd_ready, a_mem_wen, a_mem_ridx); end
        tick();
        a_cmd_valid = 2'b10; a_cmd_wen = 2'b00;
        #4;
        n_tests++; if (a_rsp_valid !== 2'b01 || a_rsp_data[63:0] !== 64'h100) begin n_fail++; $display("FAIL pr_rsp: got valid=%b data=%h want valid=01 data=100", a_rsp_valid, a_rsp_data[63:0]); end
        tick();
        a_cmd_valid = 2'b00;
        #4;
        n_tests++; if (a_rsp_valid !== 2'b10 || a_rsp_data[127:64] !== 64'hCAFE_F00D_1234_5678) begin n_fail++; $display("FAIL pr_readback: got valid=%b data=%h want valid=10 data=cafef00d12345678", a_rsp_valid, a_rsp_data[127:64]); end
        tick();
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        reset_a = 1'b0; reset_b = 1'b0; mem_load = 1'b1;
        a_cmd_valid = '0; a_cmd_addr = '0; a_cmd_wen = '0; a_cmd_wdata = '0; a_cmd_wstrb = '0; a_rsp_ready = '0;
        b_cmd_valid = '0; b_cmd_addr = '0; b_cmd_wen = '0; b_cmd_wdata = '0; b_cmd_wstrb = '0; b_rsp_ready = '0;
        tick();
        test_reset();
        test_read();
        test_write();
        test_round_robin();
        test_credit_stall();
        test_reset_inflight();
        test_write_priority();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
